// File: rtl/display_scan8.sv
// Purpose : time-multiplexed 8-digit hex scanner for a common-anode 7-segment display.
// Latency : nibble/digitselect/frame_done are registered, one cycle after idx/shadow change.
// Backpressure: none; load is a strobe into a one-deep pending slot, committed at frame end.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   value[31:0]  eight hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   load         single-cycle strobe capturing value into the pending slot
//   digit_en[7:0] per-digit enable, 0 keeps that digit dark
//   blank_lz     1 = suppress leading zeros (digit 0 is always shown)
//   nibble[3:0]  hex code of the selected digit, feeds the segment decoder
//   digitselect[7:0] active-low anode select, at most one bit low
//   frame_done   one-cycle pulse the cycle after each frame boundary
module display_scan8 #(
    parameter int DWELL = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [7:0]  digitselect,
    output logic        frame_done
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   pending;
    logic          pend_valid;
    logic [31:0]   shadow;

    logic          dwell_end;
    logic          frame_end;
    logic [7:0]    lead_zero;

    assign dwell_end = (cnt == CNT_LAST);
    assign frame_end = dwell_end && (idx == 3'd7);

    // Digit i is a leading zero when every nibble from i up to 7 is zero.
    // Walk downward accumulating "all higher nibbles zero"; digit 0 is exempt.
    always_comb begin
        logic hi_zero;
        lead_zero = 8'h00;
        hi_zero   = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            hi_zero      = hi_zero && (shadow[i*4 +: 4] == 4'h0);
            lead_zero[i] = blank_lz && hi_zero;
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= 3'd0;
        end else begin
            if (dwell_end) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Pending slot and display shadow. At a frame boundary the old pending
    // value commits first; a coincident load then refills the slot, so it is
    // shown one frame later rather than being lost or skipping ahead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending    <= 32'h0;
            pend_valid <= 1'b0;
            shadow     <= 32'h0;
        end else begin
            if (frame_end && pend_valid) begin
                shadow <= pending;
            end
            if (load) begin
                pending    <= value;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Output registers; nibble keeps tracking shadow even when the digit is dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nibble      <= 4'h0;
            digitselect <= 8'hFF;
            frame_done  <= 1'b0;
        end else begin
            nibble     <= shadow[{idx, 2'b00} +: 4];
            frame_done <= frame_end;
            if (digit_en[idx] && !lead_zero[idx]) begin
                digitselect <= ~(8'h01 << idx);
            end else begin
                digitselect <= 8'hFF;
            end
        end
    end

endmodule

// File: tb/tb_display_scan8.sv
module tb_display_scan8;

    localparam int DWELL = 4;
    localparam int FRAME = 8 * DWELL;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  nibble;
    logic [7:0]  digitselect;
    logic        frame_done;

    always #5 clk = ~clk;

    display_scan8 #(.DWELL(DWELL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value       (value),
        .load        (load),
        .digit_en    (digit_en),
        .blank_lz    (blank_lz),
        .nibble      (nibble),
        .digitselect (digitselect),
        .frame_done  (frame_done)
    );

    typedef struct packed {
        logic [3:0] nib;
        logic [7:0] sel;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int e     = 0;          // clock edges since reset release
    logic [31:0] m_shadow;
    logic [31:0] m_pend;
    logic        m_pv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h (edge %0d)", tag, obs, want, e);
        end
    endtask

    // Lit anode pattern for digit d, from the display's visible rules.
    function automatic logic [7:0] exp_sel(input logic [31:0] sh, input int d,
                                           input logic [7:0] en, input logic blz);
        if (!en[d]) return 8'hFF;
        if (d != 0 && blz && ((sh >> (4 * d)) == 32'h0)) return 8'hFF;
        return ~(8'h01 << d);
    endfunction

    // One clock: push expectation from current inputs, clock, pop and compare.
    task automatic cyc();
        exp_t x;
        int   d;
        d     = (e / DWELL) % 8;
        x.nib = m_shadow[4*d +: 4];
        x.sel = exp_sel(m_shadow, d, digit_en, blank_lz);
        x.fd  = ((e + 1) % FRAME == 0);
        sb.push_back(x);
        if ((e + 1) % FRAME == 0 && m_pv) begin
            m_shadow = m_pend;
            m_pv     = 1'b0;
        end
        if (load) begin
            m_pend = value;
            m_pv   = 1'b1;
        end
        @(posedge clk);
        e++;
        @(negedge clk);
        x = sb.pop_front();
        chk("nibble", {28'h0, nibble}, {28'h0, x.nib});
        chk("digitselect", {24'h0, digitselect}, {24'h0, x.sel});
        chk("frame_done", {31'h0, frame_done}, {31'h0, x.fd});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FRAME && (e % FRAME) != phase; i++) cyc();
    endtask

    task automatic ld(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        cyc();
        load  = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        value    = 32'h0;
        digit_en = 8'hFF;
        blank_lz = 1'b0;
        m_shadow = 32'h0;
        m_pend   = 32'h0;
        m_pv     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_nibble", {28'h0, nibble}, 32'h0);
        chk("rst_sel", {24'h0, digitselect}, 32'hFF);
        chk("rst_fd", {31'h0, frame_done}, 32'h0);
        reset_n = 1'b1;
        e = 0;

        // Load after reset: frame 0 shows zeros, frame 1 shows F..8.
        ld(32'h89ABCDEF);
        run(31);
        chk("t1_pre_nib", {28'h0, nibble}, 32'h0);
        cyc();
        chk("t1_d0_nib", {28'h0, nibble}, 32'hF);
        chk("t1_d0_sel", {24'h0, digitselect}, 32'hFE);
        run(28);
        chk("t1_d7_nib", {28'h0, nibble}, 32'h8);
        chk("t1_d7_sel", {24'h0, digitselect}, 32'h7F);
        run_to(0);

        // Two loads in one frame: only the latest is ever shown.
        run(3);
        ld(32'h12345678);
        run(5);
        ld(32'h0000ABCD);
        run_to(0);
        run(2 * FRAME);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        ld(32'h000000A0);
        run_to(0);
        run(2 * FRAME);
        ld(32'h00000000);
        run_to(0);
        run(2 * FRAME);

        // Partial enables, then a mid-frame enable change.
        blank_lz = 1'b0;
        digit_en = 8'h0F;
        ld(32'h13579BDF);
        run_to(0);
        run(FRAME + 10);
        digit_en = 8'hF0;
        run(40);
        digit_en = 8'hFF;
        run_to(0);

        // Load on the boundary cycle while another value is pending.
        ld(32'hCAFE0001);
        run_to(FRAME - 1);
        ld(32'h0BADF00D);
        chk("t5_commit_fd", {31'h0, frame_done}, 32'h1);
        run(3 * FRAME);

        // Asynchronous reset mid-dwell at idx 5, discarding a pending load.
        run_to(FRAME - 11);
        ld(32'h12121212);
        chk("t6_pre_nib", {28'h0, nibble}, 32'hA);
        chk("t6_pre_sel", {24'h0, digitselect}, 32'hDF);
        reset_n = 1'b0;
        #1;
        chk("t6_async_nib", {28'h0, nibble}, 32'h0);
        chk("t6_async_sel", {24'h0, digitselect}, 32'hFF);
        chk("t6_async_fd", {31'h0, frame_done}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        e        = 0;
        m_shadow = 32'h0;
        m_pend   = 32'h0;
        m_pv     = 1'b0;
        cyc();
        chk("t6_restart_sel", {24'h0, digitselect}, 32'hFE);
        run(2 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
